// File: rtl/match_controller_pkg.sv
// Shared types and constants for the match controller: FSM state encoding,
// winner codes, default timing parameters and a saturating score helper.
package match_controller_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COUNTDOWN  = 3'd1,
    PLAY       = 3'd2,
    ROUND_END  = 3'd3,
    MATCH_OVER = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int unsigned DEF_STEP_CYCLES = 50_000_000;
  localparam int unsigned DEF_CD_STEPS    = 3;
  localparam int unsigned DEF_WINS_NEEDED = 3;
  localparam int unsigned DEF_HOLD_CYCLES = 100_000_000;

  function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic [2:0] lim);
    return (v < lim) ? v + 3'd1 : v;
  endfunction

endpackage

// File: rtl/match_controller_if.sv
// Field-side bundle: raw keypresses and end-light levels in, gated keys and
// field clear out.
interface match_controller_if;
  logic key_l;
  logic key_r;
  logic win_l;
  logic win_r;
  logic key_l_o;
  logic key_r_o;
  logic field_clr;

  modport master (
    input  key_l, key_r, win_l, win_r,
    output key_l_o, key_r_o, field_clr
  );

  modport slave (
    output key_l, key_r, win_l, win_r,
    input  key_l_o, key_r_o, field_clr
  );
endinterface

// File: rtl/match_controller_step_timer.sv
// Free-running cycle counter with synchronous clear; wraps to zero after
// reaching the caller-supplied terminal value and flags that cycle.
module step_timer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [WIDTH-1:0] last,
  output logic             tc
);

  logic [WIDTH-1:0] cnt;

  assign tc = (cnt == last);

  always_ff @(posedge clk) begin
    if (!reset || clr || tc)
      cnt <= '0;
    else
      cnt <= cnt + WIDTH'(1);
  end

endmodule

// File: rtl/match_controller.sv
// Match sequencing for the light-field game: countdown, play, round result
// hold and match end, with false-start detection and per-player scoring.
module match_controller
  import match_controller_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int unsigned CD_STEPS    = DEF_CD_STEPS,
  parameter int unsigned WINS_NEEDED = DEF_WINS_NEEDED,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  match_controller_if.master  fld,
  output logic [1:0]          cd_val,
  output logic [2:0]          score_l,
  output logic [2:0]          score_r,
  output logic [1:0]          winner,
  output logic [2:0]          state
);

  localparam int unsigned CNT_MAX = (STEP_CYCLES > HOLD_CYCLES) ? STEP_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [1:0]       CD_LOAD   = 2'(CD_STEPS);
  localparam logic [2:0]       WINS      = 3'(WINS_NEEDED);

  state_t     cur, nxt;
  logic [1:0] cd, cd_n;
  logic [2:0] sl_n, sr_n;
  logic [1:0] win_n;
  logic       tmr_clr, tmr_tc;
  logic [CNT_W-1:0] tmr_last;

  // One counter serves both timed states; only the terminal value changes.
  assign tmr_last = (cur == COUNTDOWN) ? STEP_LAST : HOLD_LAST;

  step_timer #(.WIDTH(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .last  (tmr_last),
    .tc    (tmr_tc)
  );

  assign state         = cur;
  assign cd_val        = (cur == COUNTDOWN) ? cd : 2'd0;
  assign fld.field_clr = (cur == IDLE) || (cur == COUNTDOWN);
  assign fld.key_l_o   = (cur == PLAY) && fld.key_l;
  assign fld.key_r_o   = (cur == PLAY) && fld.key_r;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur     <= IDLE;
      cd      <= '0;
      score_l <= '0;
      score_r <= '0;
      winner  <= WIN_NONE;
    end else begin
      cur     <= nxt;
      cd      <= cd_n;
      score_l <= sl_n;
      score_r <= sr_n;
      winner  <= win_n;
    end
  end

  always_comb begin
    nxt     = cur;
    cd_n    = cd;
    sl_n    = score_l;
    sr_n    = score_r;
    win_n   = winner;
    tmr_clr = 1'b0;
    unique case (cur)
      IDLE, MATCH_OVER: begin
        tmr_clr = 1'b1;
        if (start) begin
          sl_n  = '0;
          sr_n  = '0;
          win_n = WIN_NONE;
          cd_n  = CD_LOAD;
          nxt   = COUNTDOWN;
        end
      end
      COUNTDOWN: begin
        // A keypress before PLAY is a false start and outranks the step tick.
        if (fld.key_l && fld.key_r) begin
          cd_n    = CD_LOAD;
          tmr_clr = 1'b1;
        end else if (fld.key_l) begin
          sr_n    = sat_inc(score_r, WINS);
          nxt     = ROUND_END;
          tmr_clr = 1'b1;
        end else if (fld.key_r) begin
          sl_n    = sat_inc(score_l, WINS);
          nxt     = ROUND_END;
          tmr_clr = 1'b1;
        end else if (tmr_tc) begin
          if (cd > 2'd1) cd_n = cd - 2'd1;
          else           nxt  = PLAY;
        end
      end
      PLAY: begin
        tmr_clr = 1'b1;
        if (fld.win_l || fld.win_r) begin
          if (fld.win_l && !fld.win_r) sl_n = sat_inc(score_l, WINS);
          if (fld.win_r && !fld.win_l) sr_n = sat_inc(score_r, WINS);
          nxt = ROUND_END;
        end
      end
      ROUND_END: begin
        if (tmr_tc) begin
          if (score_l == WINS || score_r == WINS) begin
            nxt   = MATCH_OVER;
            win_n = (score_r == WINS) ? WIN_P1 : WIN_P2;
          end else begin
            nxt  = COUNTDOWN;
            cd_n = CD_LOAD;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_match_controller.sv
// Randomized scoreboard bench for match_controller against a phase/elapsed-time
// reference model of the match rules.
module tb_match_controller;
  import match_controller_pkg::*;

  localparam int unsigned STEP = 4;
  localparam int unsigned CDS  = 3;
  localparam int unsigned WINS = 2;
  localparam int unsigned HOLD = 5;
  localparam int unsigned NCYC = 4000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cd_val;
  logic [2:0] score_l, score_r;
  logic [1:0] winner;
  logic [2:0] state;

  match_controller_if fld();

  match_controller #(
    .STEP_CYCLES (STEP),
    .CD_STEPS    (CDS),
    .WINS_NEEDED (WINS),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .fld     (fld),
    .cd_val  (cd_val),
    .score_l (score_l),
    .score_r (score_r),
    .winner  (winner),
    .state   (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [1:0] cd;
    logic [2:0] sl;
    logic [2:0] sr;
    logic [1:0] win;
    logic       fc;
    logic       klo;
    logic       kro;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   failed = 0;

  // Reference model: current phase, cycles elapsed in that phase, scores.
  state_t     m_mode = IDLE;
  int         m_t = 0;
  int         m_sl = 0;
  int         m_sr = 0;
  logic [1:0] m_win = WIN_NONE;
  int         n_play = 0;

  task automatic model_step();
    if (!reset) begin
      m_mode = IDLE; m_t = 0; m_sl = 0; m_sr = 0; m_win = WIN_NONE;
      return;
    end
    case (m_mode)
      IDLE, MATCH_OVER:
        if (start) begin
          m_sl = 0; m_sr = 0; m_win = WIN_NONE; m_mode = COUNTDOWN; m_t = 0;
        end
      COUNTDOWN:
        if (fld.key_l && fld.key_r) m_t = 0;
        else if (fld.key_l) begin m_sr++; m_mode = ROUND_END; m_t = 0; end
        else if (fld.key_r) begin m_sl++; m_mode = ROUND_END; m_t = 0; end
        else begin
          m_t++;
          if (m_t == int'(CDS * STEP)) begin m_mode = PLAY; m_t = 0; end
        end
      PLAY:
        if (fld.win_l || fld.win_r) begin
          if (fld.win_l && !fld.win_r) m_sl++;
          if (fld.win_r && !fld.win_l) m_sr++;
          m_mode = ROUND_END; m_t = 0;
        end
      ROUND_END: begin
        m_t++;
        if (m_t == int'(HOLD)) begin
          m_t = 0;
          if (m_sl == int'(WINS))      begin m_win = WIN_P2; m_mode = MATCH_OVER; end
          else if (m_sr == int'(WINS)) begin m_win = WIN_P1; m_mode = MATCH_OVER; end
          else m_mode = COUNTDOWN;
        end
      end
      default: m_mode = IDLE;
    endcase
  endtask

  task automatic push_expected();
    exp_t e;
    e.st  = 3'(m_mode);
    e.cd  = (m_mode == COUNTDOWN) ? 2'(int'(CDS) - m_t / int'(STEP)) : 2'd0;
    e.sl  = 3'(m_sl);
    e.sr  = 3'(m_sr);
    e.win = m_win;
    e.fc  = (m_mode == IDLE) || (m_mode == COUNTDOWN);
    e.klo = (m_mode == PLAY) && fld.key_l;
    e.kro = (m_mode == PLAY) && fld.key_r;
    q.push_back(e);
  endtask

  task automatic drive(input int c);
    int unsigned kp;
    reset = 1'b1;
    if (c == 0) reset = 1'b0;
    else if (m_mode == PLAY && n_play == 7) reset = 1'b0;
    else if ($urandom_range(499) == 0) reset = 1'b0;
    if (m_mode == PLAY) n_play++;

    start = (m_mode == IDLE || m_mode == MATCH_OVER) ? ($urandom_range(3) == 0)
                                                    : ($urandom_range(7) == 0);
    if (m_mode == COUNTDOWN) begin
      kp = $urandom_range(59);
      fld.key_l = (kp < 2) || (kp == 4);
      fld.key_r = (kp >= 2 && kp < 4) || (kp == 4);
    end else begin
      fld.key_l = ($urandom_range(2) == 0);
      fld.key_r = ($urandom_range(2) == 0);
    end
    if (m_mode == PLAY) begin
      fld.win_l = ($urandom_range(5) == 0);
      fld.win_r = ($urandom_range(5) == 0);
    end else begin
      fld.win_l = ($urandom_range(3) == 0);
      fld.win_r = ($urandom_range(3) == 0);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state",     8'(state),         8'(e.st));
        chk("cd_val",    8'(cd_val),        8'(e.cd));
        chk("score_l",   8'(score_l),       8'(e.sl));
        chk("score_r",   8'(score_r),       8'(e.sr));
        chk("winner",    8'(winner),        8'(e.win));
        chk("field_clr", 8'(fld.field_clr), 8'(e.fc));
        chk("key_l_o",   8'(fld.key_l_o),   8'(e.klo));
        chk("key_r_o",   8'(fld.key_r_o),   8'(e.kro));
      end
    end
  end

  initial begin : stimulus
    fld.key_l = 1'b0;
    fld.key_r = 1'b0;
    fld.win_l = 1'b0;
    fld.win_r = 1'b0;
    for (int c = 0; c < int'(NCYC); c++) begin
      @(posedge clk);
      model_step();
      #1;
      drive(c);
      push_expected();
    end
    @(negedge clk);
    #1;
    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
